// File: rtl/fakepll7_seq.sv
// Power-up / lock sequencer for the fakepll7 macro: holds the PLL in reset, waits for a
// stable freqlock, then releases the output clock enables and recovers from lock loss.
module fakepll7_seq #(
    parameter int NOUT   = 8,
    parameter int RSTW   = 16,
    parameter int LOCKTO = 4096,
    parameter int STABLE = 64,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              go,
    input  logic              bypass_req,
    input  logic [7:0]        cfg_divin,
    input  logic [15:0]       cfg_divfb,
    input  logic [NOUT*8-1:0] cfg_divout,
    input  logic [NOUT-1:0]   cfg_clken,
    input  logic              pll_freqlock,
    output logic              pll_reset,
    output logic              pll_en,
    output logic              pll_bypass,
    output logic [7:0]        pll_divin,
    output logic [15:0]       pll_divfb,
    output logic [NOUT*8-1:0] pll_divout,
    output logic [NOUT-1:0]   pll_clken,
    output logic              ready,
    output logic              err_timeout,
    output logic [7:0]        lockloss_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_RST    = 3'd1,
        S_WAIT   = 3'd2,
        S_STABLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t          cur_state, next_state;
    logic [CNTW-1:0] cnt, next_cnt;
    logic            sync1, lock_s;
    logic            sh_bypass;
    logic [NOUT-1:0] sh_clken;
    logic            capture, loss;
    logic            next_bypass;

    always_comb begin
        next_state = cur_state;
        next_cnt   = cnt;
        capture    = 1'b0;
        loss       = 1'b0;
        if (!go) begin
            next_state = S_OFF;
            next_cnt   = '0;
        end else begin
            case (cur_state)
                S_OFF: begin
                    capture    = 1'b1;
                    next_cnt   = '0;
                    next_state = S_RST;
                end
                S_RST: begin
                    if (cnt == CNTW'(RSTW - 1)) begin
                        next_cnt   = '0;
                        next_state = sh_bypass ? S_RUN : S_WAIT;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        next_cnt   = '0;
                        next_state = S_STABLE;
                    end else if (cnt == CNTW'(LOCKTO - 1)) begin
                        next_cnt   = '0;
                        next_state = S_FAIL;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    // Any low sample restarts both the stability window and the lock timeout.
                    if (!lock_s) begin
                        next_cnt   = '0;
                        next_state = S_WAIT;
                    end else if (cnt == CNTW'(STABLE - 1)) begin
                        next_cnt   = '0;
                        next_state = S_RUN;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s && !sh_bypass) begin
                        loss       = 1'b1;
                        next_cnt   = '0;
                        next_state = S_WAIT;
                    end
                end
                S_FAIL:  next_state = S_FAIL;
                default: next_state = S_OFF;
            endcase
        end
    end

    assign next_bypass = capture ? bypass_req : sh_bypass;
    assign state       = cur_state;

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1        <= 1'b0;
            lock_s       <= 1'b0;
            cur_state    <= S_OFF;
            cnt          <= '0;
            sh_bypass    <= 1'b0;
            sh_clken     <= '0;
            pll_divin    <= '0;
            pll_divfb    <= '0;
            pll_divout   <= '0;
            pll_reset    <= 1'b1;
            pll_en       <= 1'b0;
            pll_bypass   <= 1'b0;
            pll_clken    <= '0;
            ready        <= 1'b0;
            err_timeout  <= 1'b0;
            lockloss_cnt <= '0;
        end else begin
            sync1     <= pll_freqlock;
            lock_s    <= sync1;
            cur_state <= next_state;
            cnt       <= next_cnt;
            if (capture) begin
                sh_bypass  <= bypass_req;
                sh_clken   <= cfg_clken;
                pll_divin  <= cfg_divin;
                pll_divfb  <= cfg_divfb;
                pll_divout <= cfg_divout;
            end
            pll_reset   <= (next_state == S_OFF) || (next_state == S_RST) || (next_state == S_FAIL);
            pll_en      <= (next_state == S_RST) || (next_state == S_WAIT) ||
                           (next_state == S_STABLE) || (next_state == S_RUN);
            pll_bypass  <= (next_state != S_OFF) && next_bypass;
            pll_clken   <= (next_state == S_RUN) ? sh_clken : '0;
            ready       <= (next_state == S_RUN);
            err_timeout <= (next_state == S_FAIL);
            if (loss && (lockloss_cnt != 8'hFF))
                lockloss_cnt <= lockloss_cnt + 8'd1;
        end
    end

endmodule
